// File: rtl/jump_unit.sv
// Branch resolver feeding the program counter load port; evaluates branch
// conditions against ALU flags and keeps a return-address stack for CALL/RET.
module jump_unit #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [15:0]      count,
  input  logic             jump_req,
  input  logic [2:0]       jump_kind,
  input  logic [15:0]      target,
  input  logic             zero_flag,
  input  logic             carry_flag,
  output logic             jump_set,
  output logic [15:0]      jumpcount,
  output logic [PTR_W:0]   stack_depth,
  output logic             stack_err
);

  typedef enum logic [2:0] {
    K_JMP  = 3'd0,
    K_JZ   = 3'd1,
    K_JNZ  = 3'd2,
    K_JC   = 3'd3,
    K_JNC  = 3'd4,
    K_CALL = 3'd5,
    K_RET  = 3'd6,
    K_NOP  = 3'd7
  } kind_e;

  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] ONE  = (PTR_W + 1)'(1);

  logic             set_q, set_d;
  logic [15:0]      pc_q, pc_d;
  logic [PTR_W:0]   depth_q, depth_d;
  logic             err_q, err_d;
  logic             push;
  logic             accept;
  logic [PTR_W-1:0] top_idx;
  logic [15:0]      stack_q [DEPTH];

  // Requests arriving in the shadow slot behind a taken branch are squashed.
  assign accept  = jump_req & ~set_q;
  assign top_idx = depth_q[PTR_W-1:0] - PTR_W'(1);

  always_comb begin
    set_d   = 1'b0;
    pc_d    = pc_q;
    depth_d = depth_q;
    err_d   = err_q;
    push    = 1'b0;
    if (accept) begin
      case (kind_e'(jump_kind))
        K_JMP: begin
          set_d = 1'b1;
          pc_d  = target;
        end
        K_JZ: begin
          set_d = zero_flag;
          if (zero_flag) pc_d = target;
        end
        K_JNZ: begin
          set_d = ~zero_flag;
          if (!zero_flag) pc_d = target;
        end
        K_JC: begin
          set_d = carry_flag;
          if (carry_flag) pc_d = target;
        end
        K_JNC: begin
          set_d = ~carry_flag;
          if (!carry_flag) pc_d = target;
        end
        K_CALL: begin
          if (depth_q != FULL) begin
            push    = 1'b1;
            depth_d = depth_q + ONE;
            set_d   = 1'b1;
            pc_d    = target;
          end else begin
            err_d = 1'b1;
          end
        end
        K_RET: begin
          if (depth_q != '0) begin
            depth_d = depth_q - ONE;
            set_d   = 1'b1;
            pc_d    = stack_q[top_idx];
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      set_q   <= 1'b0;
      pc_q    <= 16'h0000;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      set_q   <= set_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Stack storage is not reset; entries above depth_q are never read.
  always_ff @(posedge clock) begin
    if (push) stack_q[depth_q[PTR_W-1:0]] <= count + 16'd1;
  end

  assign jump_set    = set_q;
  assign jumpcount   = pc_q;
  assign stack_depth = depth_q;
  assign stack_err   = err_q;

endmodule

// File: doc/jump_unit.md
# jump_unit

Control-flow resolver that drives the `jump_set`/`jumpcount` load port of the program counter. It accepts one branch request per cycle, evaluates its condition against the ALU flags, and keeps a hardware return-address stack for CALL/RET. When a branch is taken it issues a registered one-cycle load pulse with the target address. It sits between instruction decode, the ALU flag register and the program counter, and reads the current `count` back from the counter.

## Interface
Parameters:
- DEPTH, 8, number of return-address stack entries; power of two, 2..16
- PTR_W, 3, stack pointer width; must equal log2(DEPTH)

Ports:
- clock, input, 1, system clock; all state updates on rising edge
- reset, input, 1, asynchronous active-low reset
- count, input, 16, current PC value, i.e. the address of the requesting instruction
- jump_req, input, 1, a branch request is valid this cycle
- jump_kind, input, 3, request type: 0 JMP, 1 JZ, 2 JNZ, 3 JC, 4 JNC, 5 CALL, 6 RET, 7 NOP
- target, input, 16, absolute target address; ignored for RET and NOP
- zero_flag, input, 1, ALU zero flag, sampled in the request cycle
- carry_flag, input, 1, ALU carry flag, sampled in the request cycle
- jump_set, output, 1, registered one-cycle load pulse to the PC
- jumpcount, output, 16, registered address for the PC to load; valid while jump_set=1
- stack_depth, output, PTR_W+1, number of occupied stack entries, 0..DEPTH
- stack_err, output, 1, sticky flag for stack overflow or underflow

## Operation
- Request acceptance: a request is accepted when jump_req=1 and jump_set=0. While jump_set=1, any request is ignored: the instruction fetched in the shadow slot is squashed, and there is no stack change and no flag effect.
- Taken rules for an accepted request:
  - JMP: always taken.
  - JZ / JNZ: taken when zero_flag is 1 / 0.
  - JC / JNC: taken when carry_flag is 1 / 0.
  - NOP: never taken.
- CALL:
  - If stack_depth < DEPTH: push the return address (count+1, 16-bit wrap, so 0xFFFF→0x0000), increment stack_depth, and take the branch to target.
  - If stack_depth = DEPTH: no push, not taken, stack_err set to 1.
- RET:
  - If stack_depth > 0: pop the top entry, decrement stack_depth, and take the branch to the popped address.
  - If stack_depth = 0: not taken, stack_err set to 1.
- Taken request: on the next edge, jump_set←1 and jumpcount←the resolved address.
- Not-taken or no request: jump_set←0 on the next edge; jumpcount holds its last value.
- The stack is LIFO. Entries hold 16-bit addresses, and there is no wrap-around of the stack pointer.
- stack_err is cleared only by reset.
- Reset (asserted low at any time, including mid-request): immediately sets jump_set=0, jumpcount=0x0000, stack_depth=0 and stack_err=0. Stack contents need not be cleared but are unreachable after reset. A request coincident with reset assertion is lost.

## Timing
- Latency: a request accepted at edge N produces jump_set=1 during cycle N..N+1; the PC loads jumpcount at edge N+1.
- jump_set is never high for two consecutive cycles.
- Peak issue rate is one taken branch per two cycles.
- Push and pop take effect at the same edge as the jump_set update, so stack_depth reflects the request one cycle after acceptance.
- stack_err rises at the edge following the offending request.
- Flags and count are sampled only in the acceptance cycle.
- Reset deassertion is synchronous to the design (the release is externally synchronized). The first request is accepted at the first edge with reset high.

## Test plan
- Reset mid-CALL: assert reset low between edges with a CALL pending → outputs go to 0 asynchronously, stack_depth=0, and no jump_set pulse after release.
- Conditional: JZ target=0x0100 with zero_flag=1 → jump_set pulse with jumpcount=0x0100. JZ with zero_flag=0 → jump_set stays 0. Repeat for JNZ/JC/JNC.
- Call/return: count=0x0010, CALL target=0x0200 → jumpcount=0x0200, stack_depth=1. Next accepted RET → jumpcount=0x0011, stack_depth=0. Also test count=0xFFFF CALL followed by RET → jumpcount=0x0000.
- Nesting: three CALLs from 0x0001, 0x0101, 0x0201 followed by three RETs → returns to 0x0202, 0x0102, 0x0002 in that order.
- Shadow squash: JMP 0x0300 accepted, then JMP 0x0400 held on jump_req in the next cycle → only 0x0300 issued, and the 0x0400 request is ignored in the shadow cycle.
- Limits (DEPTH=8): nine CALLs → eighth ends with stack_depth=8, ninth gives no jump_set and stack_err=1. After reset, RET on an empty stack → no jump_set and stack_err=1, which stays sticky across a following valid JMP.
